sram_axi_rd_arb: RTL and testbench
==================================

# sram_axi_rd_arb

Read-channel arbiter between the instruction-fetch and data SRAM-like request ports and the single AXI3 AR/R channel pair of the CPU top. Grants one read address per cycle at most, with data priority and a starvation guard for fetch. Tracks outstanding reads per requester by ARID and routes R beats back as data_ok/rdata. Write channels (AW/W/B) are handled elsewhere; this block only observes a write-busy hint to avoid read-after-write reordering.

## Interface

Parameters:
- INST_ID, 4'd0, ARID used for fetch reads
- DATA_ID, 4'd1, ARID used for data reads
- MAX_OUTST, 2, max outstanding reads per requester (1..7)
- STARVE_LIMIT, 3, consecutive data grants while fetch waits before fetch is forced

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- inst_req  in  1  fetch read request
- inst_addr  in  32  fetch physical address
- inst_size  in  2  fetch size (0:byte, 1:half, 2:word)
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data read request
- data_addr  in  32  data physical address
- data_size  in  2  data size
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data read data valid this cycle
- data_rdata  out  32  data read data
- wr_busy  in  1  a write is in flight; blocks data reads
- arid  out  4  AR id
- araddr  out  32  AR address
- arlen  out  8  constant 0
- arsize  out  3  {1'b0, size}
- arburst  out  2  constant 2'b01
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R id
- rdata  in  32  R data
- rresp  in  2  R response (ignored)
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- rsp_err  out  1  sticky: R beat with unknown id or zero outstanding count

## Operation

- AR FSM: IDLE, AR_BUSY.
  - IDLE: grant computed; on grant, latch {arid, araddr, arsize}, go AR_BUSY.
  - AR_BUSY: arvalid=1, fields stable; on arready go IDLE.
- Eligibility: inst_ok = inst_req && cnt_inst < MAX_OUTST; data_ok_e = data_req && !wr_busy && cnt_data < MAX_OUTST.
- Grant (IDLE only): if starve counter == STARVE_LIMIT and inst_ok -> inst; else if data_ok_e -> data; else if inst_ok -> inst.
- inst_addr_ok / data_addr_ok = combinational grant pulse, at most one per cycle.
- Starve counter (0..STARVE_LIMIT): +1 on data grant while inst_req high; cleared on inst grant or when inst_req low; saturates.
- Outstanding counters cnt_inst, cnt_data (3 bits): +1 on own addr_ok; -1 on rvalid && rready && rlast && rid == own id; both same cycle -> unchanged.
- rready = 1 whenever out of reset.
- inst_data_ok = rvalid && rid==INST_ID && cnt_inst!=0; data_data_ok likewise for DATA_ID; rdata passed combinationally to both rdata outputs.
- Beat with rid not INST_ID/DATA_ID, or matching counter 0: dropped, no data_ok, rsp_err set until reset.

## Timing

- Reset (aresetn low at edge): state IDLE, arvalid 0, arid 0, araddr 0, arsize 0, rready 0, counters 0, starve 0, rsp_err 0; addr_ok and data_ok outputs forced 0 while aresetn low.
- Reset mid-transfer: arvalid drops at the next edge regardless of arready; later R beats from before reset flag rsp_err.
- Request accept: addr_ok in cycle n (IDLE), arvalid from cycle n+1 until arready.
- Back-to-back: arready at cycle k -> IDLE at k+1, next addr_ok possible at k+1, arvalid at k+2 (one AR per 2 cycles max).
- Response: data_ok same cycle as rvalid (zero latency); no buffering.
- Counter full: requester at MAX_OUTST gets no addr_ok until a beat for it returns; the decrement cycle itself may re-grant? No: grant uses registered count, so re-grant next cycle.
- wr_busy sampled combinationally in IDLE; a data request already latched in AR_BUSY is not withdrawn.

## Test plan

- Single fetch: inst_req, addr 0x1C000000, size 2, arready=1 -> inst_addr_ok cycle 0, arvalid/arid=0/araddr=0x1C000000/arsize=2 cycle 1; rvalid rid=0 rdata=0x02800C0C -> inst_data_ok with that data same cycle.
- Priority/starvation: inst_req and data_req held high, responses returned promptly -> grant order data,data,data,inst,data,...
- Outstanding limit: MAX_OUTST=2, data_req held, no R beats -> exactly 2 data_addr_ok; one rid=1 beat -> third addr_ok next IDLE cycle.
- wr_busy=1 with data_req and inst_req -> only inst granted; drop wr_busy -> data granted next IDLE cycle.
- arready held low 5 cycles -> arvalid, arid, araddr stable all 5 cycles, no addr_ok.
- Reset in AR_BUSY -> arvalid 0 next cycle; stray rid=1 beat afterwards -> rsp_err=1, no data_data_ok; rid=3 beat also sets rsp_err.

Source files
------------

// File: rtl/sram_axi_rd_arb.sv
// Read-channel arbiter: merges fetch and data SRAM-like read requests onto one
// AXI3 AR/R pair. Data has priority, and a starvation guard forces fetch after
// a run of data grants. Outstanding reads are counted per requester by ARID,
// and single-beat R responses are routed back to the requester that owns the ID.
module sram_axi_rd_arb #(
    parameter logic [3:0] INST_ID      = 4'd0,
    parameter logic [3:0] DATA_ID      = 4'd1,
    parameter int         MAX_OUTST    = 2,
    parameter int         STARVE_LIMIT = 3
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_busy,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rsp_err
);

    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [2:0]    OUTST_MAX  = 3'(MAX_OUTST);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        AR_BUSY = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [3:0]     arid_reg, arid_next;
    logic [31:0]    araddr_reg, araddr_next;
    logic [1:0]     arsize_reg, arsize_next;
    logic [2:0]     cnt_inst_reg, cnt_inst_next;
    logic [2:0]     cnt_data_reg, cnt_data_next;
    logic [SW-1:0]  starve_reg, starve_next;
    logic           rsp_err_reg, rsp_err_next;

    logic inst_elig, data_elig, force_inst;
    logic grant_inst, grant_data;
    logic r_fire, inst_hit, data_hit, inst_dec, data_dec, r_bad;

    // Eligibility and grant use registered counts, so a freed slot re-grants next cycle
    assign inst_elig  = inst_req && (cnt_inst_reg < OUTST_MAX);
    assign data_elig  = data_req && !wr_busy && (cnt_data_reg < OUTST_MAX);
    assign force_inst = (starve_reg == STARVE_MAX) && inst_elig;
    assign grant_inst = aresetn && (state_reg == IDLE) && (force_inst || (!data_elig && inst_elig));
    assign grant_data = aresetn && (state_reg == IDLE) && data_elig && !force_inst;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // R side: always ready out of reset; beats with no owner are dropped and flagged
    assign rready   = aresetn;
    assign r_fire   = rvalid && rready;
    assign inst_hit = r_fire && (rid == INST_ID) && (cnt_inst_reg != 3'd0);
    assign data_hit = r_fire && (rid == DATA_ID) && (cnt_data_reg != 3'd0);
    assign inst_dec = inst_hit && rlast;
    assign data_dec = data_hit && rlast;
    assign r_bad    = r_fire && !inst_hit && !data_hit;

    assign inst_data_ok = inst_hit;
    assign data_data_ok = data_hit;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign rsp_err      = rsp_err_reg;

    assign arvalid = (state_reg == AR_BUSY);
    assign arid    = arid_reg;
    assign araddr  = araddr_reg;
    assign arsize  = {1'b0, arsize_reg};
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    // AR FSM next state: latch the granted request, hold it until arready
    always_comb begin
        state_next  = state_reg;
        arid_next   = arid_reg;
        araddr_next = araddr_reg;
        arsize_next = arsize_reg;
        case (state_reg)
            IDLE: begin
                if (grant_inst) begin
                    arid_next   = INST_ID;
                    araddr_next = inst_addr;
                    arsize_next = inst_size;
                    state_next  = AR_BUSY;
                end else if (grant_data) begin
                    arid_next   = DATA_ID;
                    araddr_next = data_addr;
                    arsize_next = data_size;
                    state_next  = AR_BUSY;
                end
            end
            AR_BUSY: begin
                if (arready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outstanding counters, starvation counter and sticky response error
    always_comb begin
        cnt_inst_next = cnt_inst_reg;
        cnt_data_next = cnt_data_reg;
        starve_next   = starve_reg;
        rsp_err_next  = rsp_err_reg | r_bad;
        case ({grant_inst, inst_dec})
            2'b10:   cnt_inst_next = cnt_inst_reg + 3'd1;
            2'b01:   cnt_inst_next = cnt_inst_reg - 3'd1;
            default: cnt_inst_next = cnt_inst_reg;
        endcase
        case ({grant_data, data_dec})
            2'b10:   cnt_data_next = cnt_data_reg + 3'd1;
            2'b01:   cnt_data_next = cnt_data_reg - 3'd1;
            default: cnt_data_next = cnt_data_reg;
        endcase
        if (!inst_req || grant_inst) begin
            starve_next = '0;
        end else if (grant_data && (starve_reg != STARVE_MAX)) begin
            starve_next = starve_reg + SW'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg    <= IDLE;
            arid_reg     <= 4'd0;
            araddr_reg   <= 32'd0;
            arsize_reg   <= 2'd0;
            cnt_inst_reg <= 3'd0;
            cnt_data_reg <= 3'd0;
            starve_reg   <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            arid_reg     <= arid_next;
            araddr_reg   <= araddr_next;
            arsize_reg   <= arsize_next;
            cnt_inst_reg <= cnt_inst_next;
            cnt_data_reg <= cnt_data_next;
            starve_reg   <= starve_next;
            rsp_err_reg  <= rsp_err_next;
        end
    end

endmodule

// File: tb/tb_sram_axi_rd_arb.sv
// Scoreboard bench for sram_axi_rd_arb: stimulus pushes expected grants, AR
// transfers and R routings into queues; monitors pop and compare as the DUT
// presents them. A small AXI slave model answers AR transfers with R beats.
module tb_sram_axi_rd_arb;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [1:0]  size;
    } ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        inst_req, data_req, wr_busy;
    logic [31:0] inst_addr, data_addr;
    logic [1:0]  inst_size, data_size;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, rsp_err;

    int total = 0;
    int bad = 0;
    int n_grants = 0;
    bit resp_en = 1'b0;
    bit prev_grant = 1'b0;

    logic  exp_grant_q[$];   // 1 = data port, 0 = fetch port
    ar_t   exp_ar_q[$];
    beat_t exp_r_q[$];
    beat_t beat_q[$];

    always #5 clk = ~clk;

    sram_axi_rd_arb dut (
        .aclk(clk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_busy(wr_busy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .rsp_err(rsp_err)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h1C00_0000) ? 32'h0280_0C0C : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: actual=%h required=none", name, act);
    endtask

    task automatic push_txn(input bit is_data, input logic [31:0] a, input logic [1:0] sz, input bit with_r);
        ar_t   e;
        beat_t b;
        e.id   = is_data ? 4'd1 : 4'd0;
        e.addr = a;
        e.size = sz;
        exp_grant_q.push_back(is_data);
        exp_ar_q.push_back(e);
        if (with_r) begin
            b.id   = e.id;
            b.data = mem_data(a);
            exp_r_q.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int goal;
        goal = n_grants + n;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (n_grants >= goal) return;
        end
        fail_evt("grant_timeout", 64'(n_grants));
    endtask

    task automatic drain();
        repeat (6) sample();
    endtask

    initial begin
        aresetn = 1'b0; inst_req = 1'b1; data_req = 1'b1; wr_busy = 1'b0;
        inst_addr = 32'h0; data_addr = 32'h0; inst_size = 2'd2; data_size = 2'd2;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;

        fork
            // watchdog
            begin
                #200000;
                $display("FAIL watchdog: actual=timeout required=finish");
                $fatal(1, "watchdog expired");
            end
            // grant / AR / R monitor
            forever begin
                @(negedge clk);
                if (aresetn) begin
                    if (prev_grant) chk_eq("ar_latency", 64'(arvalid), 64'd1);
                    if (inst_addr_ok || data_addr_ok) begin
                        n_grants++;
                        chk_eq("grant_onehot", 64'(inst_addr_ok & data_addr_ok), 64'd0);
                        if (exp_grant_q.size() == 0) fail_evt("grant_unexpected", 64'(data_addr_ok));
                        else chk_eq("grant_port", 64'(data_addr_ok), 64'(exp_grant_q.pop_front()));
                    end
                    prev_grant = inst_addr_ok || data_addr_ok;
                    if (arvalid && arready) begin
                        if (exp_ar_q.size() == 0) fail_evt("ar_unexpected", 64'({arid, araddr}));
                        else begin
                            ar_t e;
                            e = exp_ar_q.pop_front();
                            chk_eq("ar_fields", {25'd0, arid, araddr, arsize}, {25'd0, e.id, e.addr, 1'b0, e.size});
                        end
                    end
                    if (inst_data_ok || data_data_ok) begin
                        chk_eq("rsp_onehot", 64'(inst_data_ok & data_data_ok), 64'd0);
                        if (exp_r_q.size() == 0) fail_evt("rsp_unexpected", 64'(rid));
                        else begin
                            beat_t b;
                            b = exp_r_q.pop_front();
                            chk_eq("rsp_route", {28'd0, (inst_data_ok ? 4'd0 : 4'd1),
                                                 (inst_data_ok ? inst_rdata : data_rdata)},
                                   {28'd0, b.id, b.data});
                        end
                    end
                    // slave model: answer each AR transfer with one beat next cycle
                    if (resp_en && arvalid && arready) begin
                        beat_t nb;
                        nb.id   = arid;
                        nb.data = mem_data(araddr);
                        beat_q.push_back(nb);
                    end
                end else begin
                    prev_grant = 1'b0;
                end
            end
            // R beat driver
            forever begin
                @(posedge clk);
                #1;
                if (beat_q.size() != 0) begin
                    beat_t b;
                    b = beat_q.pop_front();
                    rvalid = 1'b1; rid = b.id; rdata = b.data; rlast = 1'b1;
                end else begin
                    rvalid = 1'b0; rlast = 1'b0;
                end
            end
        join_none

        // reset state, with requests asserted to show grants are masked
        repeat (3) sample();
        chk_eq("reset_state", {arvalid, arid, araddr, arsize, rready, rsp_err},
               64'd0);
        chk_eq("reset_no_ok", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 64'd0);
        inst_req = 1'b0; data_req = 1'b0;
        step();
        aresetn = 1'b1;
        sample();
        chk_eq("rready_out_of_reset", 64'(rready), 64'd1);

        // single fetch
        resp_en = 1'b1; arready = 1'b1;
        step();
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; inst_size = 2'd2;
        push_txn(1'b0, 32'h1C00_0000, 2'd2, 1'b1);
        wait_grants(1);
        step();
        inst_req = 1'b0;
        drain();

        // priority and starvation guard: D D D I D
        step();
        inst_req = 1'b1; inst_addr = 32'h1C00_0100;
        data_req = 1'b1; data_addr = 32'h0000_1000; data_size = 2'd2;
        push_txn(1'b1, 32'h0000_1000, 2'd2, 1'b1);
        push_txn(1'b1, 32'h0000_1000, 2'd2, 1'b1);
        push_txn(1'b1, 32'h0000_1000, 2'd2, 1'b1);
        push_txn(1'b0, 32'h1C00_0100, 2'd2, 1'b1);
        push_txn(1'b1, 32'h0000_1000, 2'd2, 1'b1);
        wait_grants(5);
        step();
        inst_req = 1'b0; data_req = 1'b0;
        drain();

        // outstanding limit: two grants, then hold until a beat frees a slot
        resp_en = 1'b0;
        step();
        data_req = 1'b1; data_addr = 32'h0000_2000;
        push_txn(1'b1, 32'h0000_2000, 2'd2, 1'b0);
        push_txn(1'b1, 32'h0000_2000, 2'd2, 1'b0);
        wait_grants(2);
        begin
            int held;
            held = n_grants;
            repeat (6) sample();
            chk_eq("outst_hold", 64'(n_grants), 64'(held));
        end
        push_txn(1'b1, 32'h0000_2000, 2'd2, 1'b0);
        beat_q.push_back('{id: 4'd1, data: 32'h1111_0000});
        exp_r_q.push_back('{id: 4'd1, data: 32'h1111_0000});
        sample();
        sample();
        chk_eq("regrant_after_beat", 64'(data_addr_ok), 64'd1);
        step();
        data_req = 1'b0;
        sample();
        beat_q.push_back('{id: 4'd1, data: 32'h1111_0001});
        exp_r_q.push_back('{id: 4'd1, data: 32'h1111_0001});
        beat_q.push_back('{id: 4'd1, data: 32'h1111_0002});
        exp_r_q.push_back('{id: 4'd1, data: 32'h1111_0002});
        drain();
        chk_eq("no_rsp_err", 64'(rsp_err), 64'd0);

        // wr_busy blocks data; data follows in the next IDLE cycle
        resp_en = 1'b1;
        step();
        inst_req = 1'b1; inst_addr = 32'h1C00_0300;
        data_req = 1'b1; data_addr = 32'h0000_3000; wr_busy = 1'b1;
        push_txn(1'b0, 32'h1C00_0300, 2'd2, 1'b1);
        push_txn(1'b1, 32'h0000_3000, 2'd2, 1'b1);
        wait_grants(1);
        step();
        inst_req = 1'b0; wr_busy = 1'b0;
        sample();
        sample();
        chk_eq("data_after_wrbusy", 64'(data_addr_ok), 64'd1);
        step();
        data_req = 1'b0;
        drain();

        // arready stall: AR fields stable, no new grants
        arready = 1'b0;
        step();
        inst_req = 1'b1; inst_addr = 32'h1C00_0200; inst_size = 2'd1;
        push_txn(1'b0, 32'h1C00_0200, 2'd1, 1'b1);
        wait_grants(1);
        step();
        inst_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk_eq("ar_stall_stable", {arvalid, arid, araddr, arsize, inst_addr_ok, data_addr_ok},
                   {1'b1, 4'd0, 32'h1C00_0200, 3'd1, 1'b0, 1'b0});
        end
        step();
        arready = 1'b1;
        drain();

        // reset while AR_BUSY, then stray beats
        resp_en = 1'b0; arready = 1'b0;
        step();
        data_req = 1'b1; data_addr = 32'h0000_4000;
        exp_grant_q.push_back(1'b1);
        wait_grants(1);
        step();
        data_req = 1'b0; aresetn = 1'b0;
        sample();
        sample();
        chk_eq("reset_mid_ar", {arvalid, arid, araddr, arsize, rready}, 64'd0);
        step();
        aresetn = 1'b1;
        sample();
        beat_q.push_back('{id: 4'd1, data: 32'hBAD0_0001});
        sample();
        chk_eq("stray_no_data_ok", {inst_data_ok, data_data_ok}, 64'd0);
        sample();
        chk_eq("stray_rsp_err", 64'(rsp_err), 64'd1);
        step();
        aresetn = 1'b0;
        sample();
        sample();
        chk_eq("rsp_err_cleared", 64'(rsp_err), 64'd0);
        step();
        aresetn = 1'b1;
        sample();
        beat_q.push_back('{id: 4'd3, data: 32'hBAD0_0003});
        sample();
        chk_eq("unknown_id_no_data_ok", {inst_data_ok, data_data_ok}, 64'd0);
        sample();
        chk_eq("unknown_id_rsp_err", 64'(rsp_err), 64'd1);

        drain();
        chk_eq("grant_q_drained", 64'(exp_grant_q.size()), 64'd0);
        chk_eq("ar_q_drained", 64'(exp_ar_q.size()), 64'd0);
        chk_eq("r_q_drained", 64'(exp_r_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
